// File: rtl/game_screen_pkg.sv
// Shared types and constants for the OLED game screen scheduler.
package game_screen_pkg;

    localparam int unsigned WIDTH     = 96;
    localparam int unsigned HEIGHT    = 64;
    localparam int unsigned PIX_IDX_W = 13;
    localparam int unsigned X_W       = 7;
    localparam int unsigned Y_W       = 6;
    localparam int unsigned COLOR_W   = 16;
    localparam int unsigned NUM_SCR   = 8;
    localparam int unsigned SCR_W     = 3;
    localparam int unsigned LVL_W     = 2;
    localparam int unsigned FCNT_W    = 9;

    typedef enum logic [2:0] {
        TITLE = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        CLEAR = 3'd3,
        WIN   = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [SCR_W-1:0] SCR_TITLE  = 3'd0;
    localparam logic [SCR_W-1:0] SCR_READY  = 3'd1;
    localparam logic [SCR_W-1:0] SCR_LEVEL0 = 3'd2;
    localparam logic [SCR_W-1:0] SCR_CLEAR  = 3'd5;
    localparam logic [SCR_W-1:0] SCR_WIN    = 3'd6;
    localparam logic [SCR_W-1:0] SCR_OVER   = 3'd7;

    localparam logic [COLOR_W-1:0] BLACK = 16'h0000;
    localparam logic [COLOR_W-1:0] WHITE = 16'hFFFF;
    localparam logic [COLOR_W-1:0] RED   = 16'hF800;
    localparam logic [COLOR_W-1:0] GREEN = 16'h07E0;
    localparam logic [COLOR_W-1:0] BLUE  = 16'h001F;

    // Screen shown for a given state; level screens sit consecutively after SCR_LEVEL0.
    function automatic logic [SCR_W-1:0] target_screen(input state_t st, input logic [LVL_W-1:0] lvl);
        logic [SCR_W-1:0] scr;
        scr = SCR_TITLE;
        case (st)
            READY:   scr = SCR_READY;
            PLAY:    scr = SCR_LEVEL0 + SCR_W'(lvl);
            CLEAR:   scr = SCR_CLEAR;
            WIN:     scr = SCR_WIN;
            OVER:    scr = SCR_OVER;
            default: scr = SCR_TITLE;
        endcase
        return scr;
    endfunction

endpackage

// File: rtl/oled_pixel_coord.sv
// Registered linear pixel index to (x, y) with an out-of-range flag.
module oled_pixel_coord #(
    parameter int unsigned COLS = game_screen_pkg::WIDTH,
    parameter int unsigned ROWS = game_screen_pkg::HEIGHT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [game_screen_pkg::PIX_IDX_W-1:0] pixel_index,
    output logic [game_screen_pkg::X_W-1:0]       x,
    output logic [game_screen_pkg::Y_W-1:0]       y,
    output logic                                 oor
);
    import game_screen_pkg::*;

    logic [31:0] idx_c;
    logic        oor_c;

    assign idx_c = 32'(pixel_index);
    assign oor_c = (idx_c >= COLS * ROWS);

    // Out-of-range indices park the generators at the origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            y   <= '0;
            oor <= 1'b0;
        end else begin
            oor <= oor_c;
            if (oor_c) begin
                x <= '0;
                y <= '0;
            end else begin
                x <= X_W'(idx_c % COLS);
                y <= Y_W'(idx_c / COLS);
            end
        end
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// Game-flow FSM, frame-aligned screen selection and the two-stage pixel pipeline
// feeding the 96x64 OLED driver.
module game_screen_sequencer #(
    parameter int unsigned WIDTH        = game_screen_pkg::WIDTH,
    parameter int unsigned HEIGHT       = game_screen_pkg::HEIGHT,
    parameter int unsigned NUM_LEVELS   = 3,
    parameter int unsigned READY_FRAMES = 60,
    parameter int unsigned CLEAR_FRAMES = 90,
    parameter int unsigned OVER_FRAMES  = 300
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   frame_begin,
    input  logic [game_screen_pkg::PIX_IDX_W-1:0]  pixel_index,
    input  logic                                   btn_start,
    input  logic                                   level_done,
    input  logic                                   game_over,
    input  logic [127:0]                           pix_in,
    output logic [game_screen_pkg::X_W-1:0]        x,
    output logic [game_screen_pkg::Y_W-1:0]        y,
    output logic [game_screen_pkg::COLOR_W-1:0]    oled_data,
    output logic [game_screen_pkg::SCR_W-1:0]      screen_sel,
    output logic [game_screen_pkg::LVL_W-1:0]      level,
    output logic [2:0]                             state_o
);
    import game_screen_pkg::*;

    state_t             state_q, state_n;
    logic [LVL_W-1:0]   level_n;
    logic [FCNT_W-1:0]  frame_cnt;
    logic               btn_start_q;
    logic               oor_q;
    logic               start_edge;
    logic               ready_done, clear_done, over_done;

    oled_pixel_coord #(
        .COLS (WIDTH),
        .ROWS (HEIGHT)
    ) u_coord (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_index (pixel_index),
        .x           (x),
        .y           (y),
        .oor         (oor_q)
    );

    assign start_edge = btn_start & ~btn_start_q;
    assign ready_done = frame_begin && (frame_cnt == FCNT_W'(READY_FRAMES - 1));
    assign clear_done = frame_begin && (frame_cnt == FCNT_W'(CLEAR_FRAMES - 1));
    assign over_done  = frame_begin && (frame_cnt == FCNT_W'(OVER_FRAMES - 1));
    assign state_o    = state_q;

    // Next state and level; game_over outranks level_done in PLAY.
    always_comb begin
        state_n = state_q;
        level_n = level;
        case (state_q)
            TITLE: if (start_edge) begin
                state_n = READY;
                level_n = '0;
            end
            READY: if (ready_done) state_n = PLAY;
            PLAY: begin
                if (game_over)       state_n = OVER;
                else if (level_done) state_n = CLEAR;
            end
            CLEAR: if (clear_done) begin
                if (level == LVL_W'(NUM_LEVELS - 1)) begin
                    state_n = WIN;
                end else begin
                    level_n = level + LVL_W'(1);
                    state_n = READY;
                end
            end
            WIN:  if (start_edge) state_n = TITLE;
            OVER: if (start_edge || over_done) state_n = TITLE;
            default: begin
                state_n = TITLE;
                level_n = '0;
            end
        endcase
    end

    // State, counters, screen commit and colour stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TITLE;
            level       <= '0;
            frame_cnt   <= '0;
            btn_start_q <= 1'b0;
            screen_sel  <= SCR_TITLE;
            oled_data   <= BLACK;
        end else begin
            state_q     <= state_n;
            level       <= level_n;
            btn_start_q <= btn_start;
            if (state_n != state_q)
                frame_cnt <= '0;
            else if (frame_begin && (frame_cnt != '1))
                frame_cnt <= frame_cnt + FCNT_W'(1);
            if (frame_begin)
                screen_sel <= target_screen(state_n, level_n);
            oled_data <= oor_q ? BLACK : pix_in[{screen_sel, 4'b0000} +: COLOR_W];
        end
    end

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed bench for game_screen_sequencer: pixel pipeline, game flow and async reset.
module tb_game_screen_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_begin;
    logic [12:0]  pixel_index;
    logic         btn_start;
    logic         level_done;
    logic         game_over;
    logic [127:0] pix_in;
    logic [6:0]   x;
    logic [5:0]   y;
    logic [15:0]  oled_data;
    logic [2:0]   screen_sel;
    logic [1:0]   level;
    logic [2:0]   state_o;

    int n_cmp = 0;
    int n_err = 0;

    game_screen_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_begin (frame_begin),
        .pixel_index (pixel_index),
        .btn_start   (btn_start),
        .level_done  (level_done),
        .game_over   (game_over),
        .pix_in      (pix_in),
        .x           (x),
        .y           (y),
        .oled_data   (oled_data),
        .screen_sel  (screen_sel),
        .level       (level),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Each generator paints ~{screen, x, y}, so the colour identifies both screen and pixel.
    always_comb begin
        pix_in = '0;
        for (int k = 0; k < 8; k++)
            pix_in[16*k +: 16] = ~{3'(k), x, y};
    end

    function automatic logic [15:0] exp_col(input int scr, input int p);
        if (p >= 6144) return 16'h0000;
        return ~{3'(scr), 7'(p % 96), 6'(p / 96)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_begin = 1'b1;
            step();
            frame_begin = 1'b0;
            step();
        end
    endtask

    task automatic press();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
    endtask

    task automatic pulse_done();
        level_done = 1'b1;
        step();
        level_done = 1'b0;
    endtask

    task automatic chk_st(input string tag, input int st, input int scr, input int lvl);
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_scr"}, 32'(screen_sel), 32'(scr));
        chk({tag, "_lvl"}, 32'(level), 32'(lvl));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; frame_begin = 1'b0; pixel_index = '0;
        btn_start = 1'b0; level_done = 1'b0; game_over = 1'b0;
        #12;
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_oled", 32'(oled_data), 0);
        chk_st("rst", 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;

        // Pixel pipeline on the title screen: x/y after 1 edge, colour after 2.
        for (int i = 0; i <= 201; i++) begin
            pixel_index = 13'(i);
            step();
            chk("pix_x", 32'(x), 32'(i % 96));
            chk("pix_y", 32'(y), 32'(i / 96));
            if (i >= 1) chk("pix_col", 32'(oled_data), 32'(exp_col(0, i - 1)));
        end
        pixel_index = 13'd97;   step(); chk("i97_x", 32'(x), 1); chk("i97_y", 32'(y), 1);
        pixel_index = 13'd6143; step(); chk("i6143_x", 32'(x), 95); chk("i6143_y", 32'(y), 63);
        pixel_index = 13'd6144; step(); chk("i6144_x", 32'(x), 0); chk("i6144_y", 32'(y), 0);
        chk("i6143_col", 32'(oled_data), 32'(exp_col(0, 6143)));
        pixel_index = 13'd97;   step(); chk("i6144_black", 32'(oled_data), 32'h0000);
        step(); chk("i97_col", 32'(oled_data), 32'(exp_col(0, 97)));

        // Held start button: exactly one edge, screen waits for a frame boundary.
        btn_start = 1'b1;
        step(); chk_st("start", 1, 0, 0);
        for (int i = 0; i < 49; i++) step();
        btn_start = 1'b0; step();
        chk_st("held", 1, 0, 0);
        frames(1);  chk_st("ready_f1", 1, 1, 0);
        frames(58); chk_st("ready_f59", 1, 1, 0);
        frames(1);  chk_st("play0", 2, 2, 0);
        chk("play0_col", 32'(oled_data), 32'(exp_col(2, 97)));

        // Start ignored in PLAY; walk all three levels to WIN.
        press(); chk_st("play_btn", 2, 2, 0);
        pulse_done(); chk_st("clear0", 3, 2, 0);
        frames(1);  chk_st("clear0_f1", 3, 5, 0);
        frames(88); chk_st("clear0_f89", 3, 5, 0);
        frames(1);  chk_st("ready1", 1, 1, 1);
        frames(60); chk_st("play1", 2, 3, 1);
        pulse_done(); frames(90); chk_st("ready2", 1, 1, 2);
        frames(60); chk_st("play2", 2, 4, 2);
        pulse_done(); frames(89); chk_st("clear2_f89", 3, 5, 2);
        frames(1);  chk_st("win", 4, 6, 2);

        level_done = 1'b1; game_over = 1'b1; step();
        level_done = 1'b0; game_over = 1'b0;
        chk_st("win_ign", 4, 6, 2);
        press(); chk_st("win_title", 0, 6, 2);
        frames(1); chk_st("title_again", 0, 0, 2);

        // Simultaneous done/over in PLAY: game_over wins, then OVER timeout.
        press(); chk_st("new_game", 1, 0, 0);
        frames(60); chk_st("play0b", 2, 2, 0);
        level_done = 1'b1; game_over = 1'b1; step();
        level_done = 1'b0; game_over = 1'b0;
        chk_st("over", 5, 2, 0);
        frames(1);   chk_st("over_f1", 5, 7, 0);
        frames(298); chk_st("over_f299", 5, 7, 0);
        frames(1);   chk_st("over_tmo", 0, 0, 0);

        // Start in OVER returns to title without launching a game.
        press(); frames(60);
        game_over = 1'b1; step(); game_over = 1'b0;
        chk_st("over2", 5, 2, 0);
        btn_start = 1'b1; step(); chk_st("over_btn", 0, 2, 0);
        for (int i = 0; i < 5; i++) step();
        chk_st("over_btn_held", 0, 2, 0);
        btn_start = 1'b0; step(); chk_st("over_btn_rel", 0, 2, 0);
        press(); chk_st("fresh_edge", 1, 2, 0);

        // Reach PLAY level 1, then reset asynchronously mid-frame.
        frames(60); pulse_done(); frames(90); frames(60);
        chk_st("play1b", 2, 3, 1);
        chk("pre_rst_col", 32'(oled_data), 32'(exp_col(3, 97)));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", 32'(x), 0);
        chk("arst_y", 32'(y), 0);
        chk("arst_oled", 32'(oled_data), 0);
        chk_st("arst", 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        step(); chk("post_rst_x", 32'(x), 1);
        step(); chk("post_rst_col", 32'(oled_data), 32'(exp_col(0, 97)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
